// File: rtl/axil_ctrl_regs_if.sv
// AXI4-Lite bus bundle between the PS M00_AXI master and the control register block.
// Latency: none, wires only.
// Backpressure: carries the standard per-channel valid/ready handshakes.
interface axil_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 40
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite register block: ID, scratch, control, status, cycle counter, control output.
// Latency: write commits one edge after AW+W are both held; read data one edge after AR.
// Backpressure: one write and one read in flight; readies stay low until B/R handshake.
module axil_ctrl_regs #(
  parameter int          ADDR_WIDTH   = 40,
  parameter logic [31:0] ID_VALUE     = 32'hC0DE_0104,
  parameter logic [31:0] CTRL_OUT_RST = 32'h0000_0000
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  axil_ctrl_regs_if.slave  S_AXI,
  input  logic [31:0]      status_in,
  output logic [31:0]      ctrl_out,
  output logic             cnt_en
);

  // Word offsets (address bits [11:2])
  localparam logic [9:0] OFF_ID       = 10'd0;
  localparam logic [9:0] OFF_SCRATCH  = 10'd1;
  localparam logic [9:0] OFF_CTRL     = 10'd2;
  localparam logic [9:0] OFF_STATUS   = 10'd3;
  localparam logic [9:0] OFF_COUNT    = 10'd4;
  localparam logic [9:0] OFF_CTRL_OUT = 10'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write channel state
  logic        aw_rdy_q, aw_rdy_d;
  logic        w_rdy_q, w_rdy_d;
  logic        aw_have_q, aw_have_d;
  logic        w_have_q, w_have_d;
  logic [9:0]  aw_idx_q, aw_idx_d;
  logic [31:0] w_dat_q, w_dat_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        b_vld_q, b_vld_d;
  logic [1:0]  b_resp_q, b_resp_d;

  // Read channel state
  logic        ar_rdy_q, ar_rdy_d;
  logic        r_vld_q, r_vld_d;
  logic [31:0] r_dat_q, r_dat_d;
  logic [1:0]  r_resp_q, r_resp_d;

  // Registers
  logic [31:0] scratch_q, scratch_d;
  logic        cnt_en_q, cnt_en_d;
  logic [31:0] count_q, count_d;
  logic [31:0] ctrl_out_q, ctrl_out_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit;
  logic [9:0] ar_idx;

  // Only offset bits and the AXI-mandated fields we do not act on are left over here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI.awprot, S_AXI.arprot,
                         S_AXI.awaddr[ADDR_WIDTH-1:12], S_AXI.awaddr[1:0],
                         S_AXI.araddr[ADDR_WIDTH-1:12], S_AXI.araddr[1:0]};

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign aw_hs     = S_AXI.awvalid & aw_rdy_q;
  assign w_hs      = S_AXI.wvalid & w_rdy_q;
  assign b_hs      = b_vld_q & S_AXI.bready;
  assign ar_hs     = S_AXI.arvalid & ar_rdy_q;
  assign r_hs      = r_vld_q & S_AXI.rready;
  assign wr_commit = aw_have_q & w_have_q;
  assign ar_idx    = S_AXI.araddr[11:2];

  // Write handshakes: capture AW and W independently, commit once both are held, then respond.
  always_comb begin
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_idx_d  = aw_idx_q;
    w_dat_d   = w_dat_q;
    w_strb_d  = w_strb_q;
    b_vld_d   = b_vld_q;
    b_resp_d  = b_resp_q;
    if (aw_hs) begin
      aw_have_d = 1'b1;
      aw_idx_d  = S_AXI.awaddr[11:2];
    end
    if (w_hs) begin
      w_have_d = 1'b1;
      w_dat_d  = S_AXI.wdata;
      w_strb_d = S_AXI.wstrb;
    end
    if (wr_commit) begin
      aw_have_d = 1'b0;
      w_have_d  = 1'b0;
      b_vld_d   = 1'b1;
      b_resp_d  = (aw_idx_q > OFF_CTRL_OUT) ? RESP_DECERR : RESP_OKAY;
    end else if (b_hs) begin
      b_vld_d = 1'b0;
    end
    // Readies come back on the edge that retires the response (3-cycle write throughput).
    aw_rdy_d = ~aw_have_d & ~b_vld_d;
    w_rdy_d  = ~w_have_d & ~b_vld_d;
  end

  // Register updates: counter runs on the old enable; a clear on the commit edge wins.
  always_comb begin
    scratch_d  = scratch_q;
    cnt_en_d   = cnt_en_q;
    ctrl_out_d = ctrl_out_q;
    count_d    = count_q + {31'd0, cnt_en_q};
    if (wr_commit) begin
      case (aw_idx_q)
        OFF_SCRATCH:  scratch_d = apply_strb(scratch_q, w_dat_q, w_strb_q);
        OFF_CTRL: begin
          if (w_strb_q[0]) begin
            cnt_en_d = w_dat_q[0];
            if (w_dat_q[1]) begin
              count_d = 32'd0;
            end
          end
        end
        OFF_CTRL_OUT: ctrl_out_d = apply_strb(ctrl_out_q, w_dat_q, w_strb_q);
        default: ;
      endcase
    end
  end

  // Read path: register data on the AR edge from pre-commit register values; hold until R handshake.
  always_comb begin
    r_vld_d  = r_vld_q;
    r_dat_d  = r_dat_q;
    r_resp_d = r_resp_q;
    if (ar_hs) begin
      r_vld_d  = 1'b1;
      r_resp_d = RESP_OKAY;
      case (ar_idx)
        OFF_ID:       r_dat_d = ID_VALUE;
        OFF_SCRATCH:  r_dat_d = scratch_q;
        OFF_CTRL:     r_dat_d = {31'd0, cnt_en_q};
        OFF_STATUS:   r_dat_d = status_in;
        OFF_COUNT:    r_dat_d = count_q;
        OFF_CTRL_OUT: r_dat_d = ctrl_out_q;
        default: begin
          r_dat_d  = 32'd0;
          r_resp_d = RESP_DECERR;
        end
      endcase
    end else if (r_hs) begin
      r_vld_d = 1'b0;
    end
    ar_rdy_d = ~r_vld_d;
  end

  // State flops; reset drops any transaction in flight and holds all readies low.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_rdy_q   <= 1'b0;
      w_rdy_q    <= 1'b0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      aw_idx_q   <= 10'd0;
      w_dat_q    <= 32'd0;
      w_strb_q   <= 4'd0;
      b_vld_q    <= 1'b0;
      b_resp_q   <= 2'b00;
      ar_rdy_q   <= 1'b0;
      r_vld_q    <= 1'b0;
      r_dat_q    <= 32'd0;
      r_resp_q   <= 2'b00;
      scratch_q  <= 32'd0;
      cnt_en_q   <= 1'b0;
      count_q    <= 32'd0;
      ctrl_out_q <= CTRL_OUT_RST;
    end else begin
      aw_rdy_q   <= aw_rdy_d;
      w_rdy_q    <= w_rdy_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      aw_idx_q   <= aw_idx_d;
      w_dat_q    <= w_dat_d;
      w_strb_q   <= w_strb_d;
      b_vld_q    <= b_vld_d;
      b_resp_q   <= b_resp_d;
      ar_rdy_q   <= ar_rdy_d;
      r_vld_q    <= r_vld_d;
      r_dat_q    <= r_dat_d;
      r_resp_q   <= r_resp_d;
      scratch_q  <= scratch_d;
      cnt_en_q   <= cnt_en_d;
      count_q    <= count_d;
      ctrl_out_q <= ctrl_out_d;
    end
  end

  assign S_AXI.awready = aw_rdy_q;
  assign S_AXI.wready  = w_rdy_q;
  assign S_AXI.bvalid  = b_vld_q;
  assign S_AXI.bresp   = b_resp_q;
  assign S_AXI.arready = ar_rdy_q;
  assign S_AXI.rvalid  = r_vld_q;
  assign S_AXI.rdata   = r_dat_q;
  assign S_AXI.rresp   = r_resp_q;
  assign ctrl_out      = ctrl_out_q;
  assign cnt_en        = cnt_en_q;

endmodule

// File: doc/axil_ctrl_regs.md
Name: axil_ctrl_regs

Overview:
- AXI4-Lite slave register block that directly consumes the M00_AXI master port exported by the PS block design.
- Gives software a fixed register map: ID, scratch, control, status, cycle counter and a general-purpose control output.
- Runs in the axi_aclk domain, reset by axi_aresetn.
- Upper address bits are already decoded by the interconnect; this block decodes offset bits [11:2] only.

Parameters:
ADDR_WIDTH, 40, width of awaddr/araddr; only bits [11:2] decoded, rest ignored
ID_VALUE, 32'hC0DE_0104, constant returned at offset 0x00
CTRL_OUT_RST, 32'h0000_0000, reset value of the CTRL_OUT register

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
S_AXI_awaddr  in  ADDR_WIDTH  write address
S_AXI_awprot  in  3  ignored
S_AXI_awvalid  in  1  write address valid
S_AXI_awready  out  1  write address ready
S_AXI_wdata  in  32  write data
S_AXI_wstrb  in  4  byte enables
S_AXI_wvalid  in  1  write data valid
S_AXI_wready  out  1  write data ready
S_AXI_bresp  out  2  write response
S_AXI_bvalid  out  1  write response valid
S_AXI_bready  in  1  write response ready
S_AXI_araddr  in  ADDR_WIDTH  read address
S_AXI_arprot  in  3  ignored
S_AXI_arvalid  in  1  read address valid
S_AXI_arready  out  1  read address ready
S_AXI_rdata  out  32  read data
S_AXI_rresp  out  2  read response
S_AXI_rvalid  out  1  read data valid
S_AXI_rready  in  1  read data ready
status_in  in  32  fabric status, synchronous to axi_aclk
ctrl_out  out  32  CTRL_OUT register contents
cnt_en  out  1  CTRL[0]

Behaviour:
- Reset (async assert, sync release) forces:
  - all ready/valid outputs 0; bresp, rresp, rdata = 0
  - SCRATCH = 0, CTRL = 0, COUNT = 0, CTRL_OUT = CTRL_OUT_RST
  - awready, wready, arready = 1 from the first rising edge after release
- Register map (offset from addr[11:2]):
  - 0x00 ID: RO, returns ID_VALUE
  - 0x04 SCRATCH: RW
  - 0x08 CTRL: RW. bit0 = counter enable. bit1 = counter clear: write-1 pulse, always reads 0. Other bits read 0.
  - 0x0C STATUS: RO, returns status_in, sampled in the AR handshake cycle
  - 0x10 COUNT: RO, 32-bit cycle counter
  - 0x14 CTRL_OUT: RW
- Write channel:
  - AW and W are accepted independently; each ready drops after its own handshake.
  - When both are captured (same edge or different edges), the write commits on the next edge, with wstrb byte masking on RW registers.
  - bvalid rises on the commit edge and holds until bready.
  - awready and wready re-assert on the edge after the B handshake.
  - Maximum one outstanding write. Write-to-accept throughput is 3 cycles when bready is held high.
- Write responses:
  - Offsets 0x00–0x14: OKAY (2'b00). Writes to RO offsets are ignored but still OKAY.
  - Offset > 0x14: DECERR (2'b11), no state change.
- Read channel:
  - arready is 1 when no read response is pending.
  - On the AR handshake edge, rdata/rresp are registered and rvalid is set; 1-cycle latency.
  - rvalid, rdata and rresp hold stable until rready. arready returns on the edge after the R handshake.
  - Unmapped offset: rdata = 0, rresp = DECERR.
- Read/write collision: a read and write commit on the same edge to the same register returns the pre-write value.
- Counter:
  - Increments by 1 each cycle while CTRL[0] = 1; wraps 0xFFFF_FFFF -> 0.
  - A CTRL write with bit1 = 1 zeroes COUNT on the commit edge; clear wins over increment.
  - If wstrb[0] = 0, the CTRL write has no effect on bit0 or bit1.
- Outputs: ctrl_out and cnt_en are driven straight from registers and change on the commit edge.
- Reset mid-transaction: the pending transaction is dropped; no bvalid/rvalid after reset.

Test Plan:
- Post-reset: read 0x00 -> rdata = 32'hC0DE_0104, OKAY; ctrl_out = 0, cnt_en = 0.
- Write 0x04 = 32'hA5A5_1234, wstrb = 4'b0101, W presented 3 cycles after AW; read back -> 32'h00A5_0034; one bvalid pulse with OKAY.
- Write CTRL = 1, wait 100 cycles, write CTRL = 0; read COUNT -> 100 ± write-path latency. Write CTRL = 2; read COUNT -> 0, and CTRL reads 0.
- Write 0x20 -> bresp = 2'b11; read 0x40 -> rdata = 0, rresp = 2'b11; SCRATCH unchanged.
- Back-pressure: hold bready/rready low 10 cycles -> bvalid/rvalid and rdata stable; awready, wready and arready stay 0 until the handshake.
- Assert axi_aresetn low while bvalid is pending -> bvalid = 0 immediately; CTRL_OUT = CTRL_OUT_RST; readies = 1 on the first edge after release.
